// File: rtl/param_sync_fifo_pkg.sv
// Shared defaults and width helpers for the synchronous FIFO.
// Pointers carry one extra wrap bit above the memory address.
package param_sync_fifo_pkg;

   localparam int DEFAULT_DATA_W = 16;
   localparam int DEFAULT_DEPTH  = 8;

   function automatic int addr_w(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/param_sync_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port.
// A same-address read and write returns the old word.
module fifo_ram
   import param_sync_fifo_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int DEPTH  = DEFAULT_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [addr_w(DEPTH)-1:0] waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic                     re,
   input  logic [addr_w(DEPTH)-1:0] raddr,
   output logic [DATA_W-1:0]        rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   // Only the output register is reset; the array itself keeps its contents.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata <= '0;
      end else if (re) begin
         r_rdata <= r_mem[raddr];
      end
   end

   assign rdata = r_rdata;

endmodule

// File: rtl/param_sync_fifo.sv
// Synchronous FIFO: pointers, occupancy count, level flags and sticky errors.
// A write into a full FIFO is accepted when a read is accepted in the same cycle.
module param_sync_fifo
   import param_sync_fifo_pkg::*;
#(
   parameter int DATA_W    = DEFAULT_DATA_W,
   parameter int DEPTH     = DEFAULT_DEPTH,
   parameter int AFULL_TH  = DEPTH - 2,
   parameter int AEMPTY_TH = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr,
   input  logic [DATA_W-1:0]       data_in,
   input  logic                    rd,
   input  logic                    clr_err,
   output logic [DATA_W-1:0]       data_out,
   output logic                    rd_valid,
   output logic                    fifo_full,
   output logic                    fifo_empty,
   output logic                    almost_full,
   output logic                    almost_empty,
   output logic [cnt_w(DEPTH)-1:0] count,
   output logic                    fifo_overflow,
   output logic                    fifo_underflow
);

   localparam int AW = addr_w(DEPTH);
   localparam int PW = ptr_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   localparam logic [CW-1:0] FULL_V   = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_V  = CW'(AFULL_TH);
   localparam logic [CW-1:0] AEMPTY_V = CW'(AEMPTY_TH);

   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic [CW-1:0] w_count_next;
   logic          r_rd_valid;
   logic          r_ovf;
   logic          r_udf;
   logic          w_full;
   logic          w_empty;
   logic          w_rd_acc;
   logic          w_wr_acc;

   // Flags decode registered count only, so requests never reach them.
   assign w_full   = (r_count == FULL_V);
   assign w_empty  = (r_count == '0);
   assign w_rd_acc = rd & ~w_empty;
   assign w_wr_acc = wr & (~w_full | w_rd_acc);

   always_comb begin
      w_count_next = r_count;
      case ({w_wr_acc, w_rd_acc})
         2'b10:   w_count_next = r_count + 1'b1;
         2'b01:   w_count_next = r_count - 1'b1;
         default: w_count_next = r_count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_rd_valid <= 1'b0;
         r_ovf      <= 1'b0;
         r_udf      <= 1'b0;
      end else begin
         if (w_wr_acc) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_rd_acc) begin
            r_rptr <= r_rptr + 1'b1;
         end
         r_count    <= w_count_next;
         r_rd_valid <= w_rd_acc;
         // A new error in the same cycle as clr_err keeps the flag set.
         r_ovf      <= (wr & ~w_wr_acc) | (r_ovf & ~clr_err);
         r_udf      <= (rd & ~w_rd_acc) | (r_udf & ~clr_err);
      end
   end

   fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (w_wr_acc),
      .waddr (r_wptr[AW-1:0]),
      .wdata (data_in),
      .re    (w_rd_acc),
      .raddr (r_rptr[AW-1:0]),
      .rdata (data_out)
   );

   assign rd_valid       = r_rd_valid;
   assign fifo_full      = w_full;
   assign fifo_empty     = w_empty;
   assign almost_full    = (r_count >= AFULL_V);
   assign almost_empty   = (r_count <= AEMPTY_V);
   assign count          = r_count;
   assign fifo_overflow  = r_ovf;
   assign fifo_underflow = r_udf;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo (DATA_W=16, DEPTH=8, AFULL_TH=6, AEMPTY_TH=2).
module tb_param_sync_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr;
   logic [15:0] data_in;
   logic        rd;
   logic        clr_err;
   logic [15:0] data_out;
   logic        rd_valid;
   logic        fifo_full;
   logic        fifo_empty;
   logic        almost_full;
   logic        almost_empty;
   logic [3:0]  count;
   logic        fifo_overflow;
   logic        fifo_underflow;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   param_sync_fifo #(
      .DATA_W    (16),
      .DEPTH     (8),
      .AFULL_TH  (6),
      .AEMPTY_TH (2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .wr             (wr),
      .data_in        (data_in),
      .rd             (rd),
      .clr_err        (clr_err),
      .data_out       (data_out),
      .rd_valid       (rd_valid),
      .fifo_full      (fifo_full),
      .fifo_empty     (fifo_empty),
      .almost_full    (almost_full),
      .almost_empty   (almost_empty),
      .count          (count),
      .fifo_overflow  (fifo_overflow),
      .fifo_underflow (fifo_underflow)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; wr = 1'b0; rd = 1'b0; clr_err = 1'b0; data_in = '0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_count", 32'(count), 0);
      check("rst_empty", 32'(fifo_empty), 1);
      check("rst_aempty", 32'(almost_empty), 1);
      check("rst_full", 32'(fifo_full), 0);
      check("rst_flags", {30'd0, fifo_overflow, fifo_underflow}, 0);
      check("rst_rdv", 32'(rd_valid), 0);
      check("rst_dout", 32'(data_out), 0);

      // Fill with 1..8
      for (int i = 1; i <= 8; i++) begin
         wr = 1'b1; data_in = 16'(i);
         tick();
         check($sformatf("fill_count_%0d", i), 32'(count), 32'(i));
         check($sformatf("fill_afull_%0d", i), 32'(almost_full), (i >= 6) ? 1 : 0);
         check($sformatf("fill_aempty_%0d", i), 32'(almost_empty), (i <= 2) ? 1 : 0);
         check($sformatf("fill_full_%0d", i), 32'(fifo_full), (i == 8) ? 1 : 0);
         check($sformatf("fill_ovf_%0d", i), 32'(fifo_overflow), 0);
      end

      // Rejected write on full
      data_in = 16'h00AA;
      tick();
      wr = 1'b0;
      check("ovf_count", 32'(count), 8);
      check("ovf_set", 32'(fifo_overflow), 1);
      tick();
      check("ovf_sticky", 32'(fifo_overflow), 1);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check("ovf_clr", 32'(fifo_overflow), 0);

      // Write plus read on full
      wr = 1'b1; rd = 1'b1; data_in = 16'h00BB;
      tick();
      wr = 1'b0;
      check("fullrw_dout", 32'(data_out), 32'h0001);
      check("fullrw_rdv", 32'(rd_valid), 1);
      check("fullrw_count", 32'(count), 8);
      check("fullrw_ovf", 32'(fifo_overflow), 0);
      for (int k = 0; k < 8; k++) begin
         tick();
         check($sformatf("drain_dout_%0d", k), 32'(data_out), (k < 7) ? 32'(k + 2) : 32'h00BB);
         check($sformatf("drain_rdv_%0d", k), 32'(rd_valid), 1);
      end
      rd = 1'b0;
      tick();
      check("drain_rdv_idle", 32'(rd_valid), 0);
      check("drain_empty", 32'(fifo_empty), 1);
      check("drain_hold", 32'(data_out), 32'h00BB);
      check("drain_udf", 32'(fifo_underflow), 0);

      // Write plus read on empty
      wr = 1'b1; rd = 1'b1; data_in = 16'h1234;
      tick();
      wr = 1'b0;
      check("emptyrw_udf", 32'(fifo_underflow), 1);
      check("emptyrw_rdv", 32'(rd_valid), 0);
      check("emptyrw_count", 32'(count), 1);
      tick();
      rd = 1'b0;
      check("emptyrw_dout", 32'(data_out), 32'h1234);
      check("emptyrw_rdv2", 32'(rd_valid), 1);
      check("emptyrw_count2", 32'(count), 0);

      // Set beats clear in the same cycle
      rd = 1'b1; clr_err = 1'b1;
      tick();
      rd = 1'b0;
      check("setwins_udf", 32'(fifo_underflow), 1);
      tick();
      clr_err = 1'b0;
      check("udf_clr", 32'(fifo_underflow), 0);

      // 20 write/read pairs; addresses wrap past the end of memory twice
      for (int i = 0; i < 20; i++) begin
         wr = 1'b1; data_in = 16'(16'h0100 + i);
         tick();
         wr = 1'b0; rd = 1'b1;
         tick();
         rd = 1'b0;
         check($sformatf("wrap_dout_%0d", i), 32'(data_out), 32'h0100 + 32'(i));
      end
      check("wrap_count", 32'(count), 0);
      check("wrap_empty", 32'(fifo_empty), 1);
      check("wrap_aempty", 32'(almost_empty), 1);

      // Build count=5 with both flags set, then reset
      rd = 1'b1;
      tick();
      rd = 1'b0;
      for (int i = 0; i < 9; i++) begin
         wr = 1'b1; data_in = 16'(16'h0A00 + i);
         tick();
      end
      wr = 1'b0;
      rd = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      rd = 1'b0;
      check("pre_rst_count", 32'(count), 5);
      check("pre_rst_flags", {30'd0, fifo_overflow, fifo_underflow}, 3);
      check("pre_rst_dout", 32'(data_out), 32'h0A02);
      rst = 1'b1; wr = 1'b1; rd = 1'b1; clr_err = 1'b0; data_in = 16'hFFFF;
      tick();
      rst = 1'b0; wr = 1'b0; rd = 1'b0;
      check("midrst_count", 32'(count), 0);
      check("midrst_empty", 32'(fifo_empty), 1);
      check("midrst_flags", {30'd0, fifo_overflow, fifo_underflow}, 0);
      check("midrst_rdv", 32'(rd_valid), 0);
      check("midrst_dout", 32'(data_out), 0);

      // Operation resumes cleanly after reset
      wr = 1'b1; data_in = 16'h5A5A;
      tick();
      wr = 1'b0; rd = 1'b1;
      tick();
      rd = 1'b0;
      check("post_rst_dout", 32'(data_out), 32'h5A5A);
      check("post_rst_count", 32'(count), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
